// File: rtl/rf_wport_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wport_arbiter_pkg
//  Purpose  : Shared constants for the register-file write-port arbiter:
//             FSM state encodings and the default register address width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package rf_wport_arbiter_pkg;

   // Register address width and the width of the pending-flag vector
   localparam int REG_ADDR_W = 5;
   localparam int PEND_W     = 32;

   // Arbiter FSM state encodings
   typedef logic [1:0] arb_state_t;
   localparam arb_state_t ST_NORMAL = 2'd0;  // WB has the port, mult drains in idle slots
   localparam arb_state_t ST_FORCE  = 2'd1;  // one slot stolen from WB for the FIFO head
   localparam arb_state_t ST_DRAIN  = 2'd2;  // WB blocked until the FIFO is empty

endpackage : rf_wport_arbiter_pkg
`default_nettype wire

// File: rtl/rf_arb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rf_arb_fifo
//  Purpose  : Synchronous FIFO of {addr,data} multiplier results. Pointers
//             carry an extra MSB so full and empty are distinguishable.
//             Also decodes a per-register "pending" vector: bit i is set when
//             any live entry targets register i (bit 0 never set).
//  Ports    : clk, rst (async, active-low)
//             enq/enq_addr/enq_data  - push (ignored when full)
//             deq                    - pop head (ignored when empty)
//             head_addr/head_data    - current head entry
//             full, empty            - occupancy flags
//             pend_flags             - OR of one-hot(addr) over live entries
//  Revision : 1.0  initial release
// ============================================================================
module rf_arb_fifo
   import rf_wport_arbiter_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enq,
   input  logic [ADDR_W-1:0] enq_addr,
   input  logic [DATA_W-1:0] enq_data,
   input  logic              deq,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data,
   output logic              full,
   output logic              empty,
   output logic [PEND_W-1:0] pend_flags
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W:0]    wr_ptr;
   logic [PTR_W:0]    rd_ptr;
   logic [PTR_W:0]    count;
   logic              do_enq;
   logic              do_deq;
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign count     = wr_ptr - rd_ptr;
   assign do_enq    = enq && !full;
   assign do_deq    = deq && !empty;
   assign head_addr = addr_mem[rd_ptr[PTR_W-1:0]];
   assign head_data = data_mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_enq) wr_ptr <= wr_ptr + 1'b1;
         if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Payload storage needs no reset: only entries between the pointers are read
   always_ff @(posedge clk) begin
      if (do_enq) begin
         addr_mem[wr_ptr[PTR_W-1:0]] <= enq_addr;
         data_mem[wr_ptr[PTR_W-1:0]] <= enq_data;
      end
   end

   // Slot i is live when its distance from the read pointer is below the count
   always_comb begin
      logic [PTR_W-1:0] offset;
      pend_flags = '0;
      offset     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset = PTR_W'(i) - rd_ptr[PTR_W-1:0];
         if ({1'b0, offset} < count) begin
            for (int r = 1; r < PEND_W; r++) begin
               if (int'(addr_mem[i]) == r) pend_flags[r] = 1'b1;
            end
         end
      end
   end

endmodule : rf_arb_fifo
`default_nettype wire

// File: rtl/rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_wport_arbiter
//  Purpose  : Shares a single register-file write port between pipeline
//             writeback (WB) and multiplier results. Mult results queue in
//             rf_arb_fifo and drain in idle WB slots; after STARVE_MAX WB
//             grants with a non-empty FIFO, one slot is forced for the FIFO.
//             drain_req blocks WB until the FIFO is empty.
//  Ports    : clk, rst (async, active-low)
//             wb_valid/wb_ready/wb_addr/wb_data     - WB write request
//             mul_valid/mul_ready/mul_addr/mul_data - mult result
//             drain_req (level) / drain_done (1-cycle pulse)
//             rf_we/rf_waddr/rf_wdata               - registered write port
//             pend_flags, fifo_full                 - status for stall control
//  Config   : RF_ARB_BYPASS_EN - when defined, a mult result arriving in
//             NORMAL with the FIFO empty and WB idle goes straight to the
//             write port instead of being queued.
//  Revision : 1.0  initial release
// ============================================================================
module rf_wport_arbiter
   import rf_wport_arbiter_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int ADDR_W     = REG_ADDR_W,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              mul_valid,
   output logic              mul_ready,
   input  logic [ADDR_W-1:0] mul_addr,
   input  logic [DATA_W-1:0] mul_data,
   input  logic              drain_req,
   output logic              drain_done,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [PEND_W-1:0] pend_flags,
   output logic              fifo_full
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic [CNT_W-1:0]  starve_cnt;
   logic [CNT_W-1:0]  starve_nxt;
   logic              fifo_empty;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic              mul_acc;
   logic              wb_grant;
   logic              deq;
   logic              enq;
   logic              bypass;
   logic              drain_done_nxt;
   logic              we_nxt;
   logic [ADDR_W-1:0] waddr_nxt;
   logic [DATA_W-1:0] wdata_nxt;

   // Accepting while full is refused even if the head leaves this cycle
   assign mul_ready = !fifo_full;
   assign mul_acc   = mul_valid && mul_ready;
   assign wb_ready  = (state == ST_NORMAL);
   // x0 results are acknowledged and dropped
   assign enq       = mul_acc && (mul_addr != '0) && !bypass;

   rf_arb_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .enq        (enq),
      .enq_addr   (mul_addr),
      .enq_data   (mul_data),
      .deq        (deq),
      .head_addr  (head_addr),
      .head_data  (head_data),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .pend_flags (pend_flags)
   );

   // Arbitration and next-state logic
   always_comb begin
      state_nxt      = state;
      starve_nxt     = starve_cnt;
      wb_grant       = 1'b0;
      deq            = 1'b0;
      bypass         = 1'b0;
      drain_done_nxt = 1'b0;
      case (state)
         ST_NORMAL: begin
            if (wb_valid) begin
               wb_grant = 1'b1;
               if (!fifo_empty) begin
                  if (int'(starve_cnt) < STARVE_MAX) starve_nxt = starve_cnt + 1'b1;
                  if (int'(starve_cnt) + 1 >= STARVE_MAX) state_nxt = ST_FORCE;
               end
            end else if (!fifo_empty) begin
               deq        = 1'b1;
               starve_nxt = '0;
            end
`ifdef RF_ARB_BYPASS_EN
            else if (mul_acc && (mul_addr != '0)) begin
               bypass = 1'b1;
            end
`endif
            // A drain request overrides a pending forced slot
            if (drain_req) state_nxt = ST_DRAIN;
         end
         ST_FORCE: begin
            deq        = !fifo_empty;
            starve_nxt = '0;
            state_nxt  = drain_req ? ST_DRAIN : ST_NORMAL;
         end
         ST_DRAIN: begin
            deq = !fifo_empty;
            // Wait for in-flight mult results too, so the FIFO is truly quiet
            if (fifo_empty && !mul_valid) begin
               state_nxt      = ST_NORMAL;
               drain_done_nxt = 1'b1;
            end
         end
         default: state_nxt = ST_NORMAL;
      endcase
      if (fifo_empty) starve_nxt = '0;
   end

   // Write-port mux. WB to a pending register is a stall-control violation,
   // but both writes still occur, in grant order.
   always_comb begin
      we_nxt    = 1'b0;
      waddr_nxt = wb_addr;
      wdata_nxt = wb_data;
      if (wb_grant) begin
         we_nxt = (wb_addr != '0);
      end else if (deq) begin
         we_nxt    = 1'b1;
         waddr_nxt = head_addr;
         wdata_nxt = head_data;
      end else if (bypass) begin
         we_nxt    = 1'b1;
         waddr_nxt = mul_addr;
         wdata_nxt = mul_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_NORMAL;
         starve_cnt <= '0;
         drain_done <= 1'b0;
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         drain_done <= drain_done_nxt;
         rf_we      <= we_nxt;
         if (we_nxt) begin
            rf_waddr <= waddr_nxt;
            rf_wdata <= wdata_nxt;
         end
      end
   end

endmodule : rf_wport_arbiter
`default_nettype wire

// File: tb/tb_rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_wport_arbiter
//  Purpose  : Self-checking bench for rf_wport_arbiter. A scoreboard queue
//             holds expected register-file writes in grant order; a monitor
//             pops and compares on every rf_we. Directed checks cover
//             ready/full/pending/drain timing. Honours RF_ARB_BYPASS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rf_wport_arbiter;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              wb_valid, wb_ready, mul_valid, mul_ready;
   logic [ADDR_W-1:0] wb_addr, mul_addr, rf_waddr;
   logic [DATA_W-1:0] wb_data, mul_data, rf_wdata;
   logic              drain_req, drain_done, rf_we, fifo_full;
   logic [31:0]       pend_flags;

   always #5 clk = ~clk;

   rf_wport_arbiter #(
      .DEPTH(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(3)
   ) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
      .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_addr(mul_addr), .mul_data(mul_data),
      .drain_req(drain_req), .drain_done(drain_done),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .pend_flags(pend_flags), .fifo_full(fifo_full)
   );

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   typedef struct packed {
      logic              wbv;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              exp_we;
   } vec_t;

   wr_t sb[$];
   int  total = 0;
   int  bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      sb.push_back(wr_t'{addr: a, data: d});
   endtask

   task automatic wb(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wb_valid = v; wb_addr = a; wb_data = d;
   endtask

   task automatic mul(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      mul_valid = v; mul_addr = a; mul_data = d;
   endtask

   task automatic idle(input int n);
      wb_valid = 1'b0; mul_valid = 1'b0; drain_req = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard monitor: every register-file write must match the next expected one
   always @(negedge clk) begin
      wr_t e;
      if (rst && rf_we) begin
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL rf_write_unexpected: got addr=%0d data=%0h expected no write",
                     rf_waddr, rf_wdata);
         end else begin
            e = sb.pop_front();
            chk("rf_write_addr", 64'(rf_waddr), 64'(e.addr));
            chk("rf_write_data", 64'(rf_wdata), 64'(e.data));
         end
      end
   end

   initial begin
      vec_t vecs [5];
      vecs[0] = '{1'b1, 5'd5,  32'hA5A5_A5A5, 1'b1};
      vecs[1] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 1'b0};  // x0: handshake only
      vecs[2] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1};
      vecs[3] = '{1'b0, 5'd9,  32'h0000_1234, 1'b0};
      vecs[4] = '{1'b1, 5'd1,  32'h0000_0001, 1'b1};

      wb(1'b0, '0, '0); mul(1'b0, '0, '0); drain_req = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // ---- reset state ----
      chk("rst_rf_we",      64'(rf_we),      64'd0);
      chk("rst_rf_waddr",   64'(rf_waddr),   64'd0);
      chk("rst_rf_wdata",   64'(rf_wdata),   64'd0);
      chk("rst_drain_done", 64'(drain_done), 64'd0);
      chk("rst_pend",       64'(pend_flags), 64'd0);
      chk("rst_fifo_full",  64'(fifo_full),  64'd0);
      chk("rst_wb_ready",   64'(wb_ready),   64'd1);
      chk("rst_mul_ready",  64'(mul_ready),  64'd1);
      rst = 1'b1;
      @(negedge clk);

      // ---- table: back-to-back WB writes, 1-cycle latency ----
      for (int i = 0; i < 5; i++) begin
         wb(vecs[i].wbv, vecs[i].addr, vecs[i].data);
         if (vecs[i].exp_we) push(vecs[i].addr, vecs[i].data);
         @(negedge clk);
         chk($sformatf("vec%0d_rf_we", i), 64'(rf_we), 64'(vecs[i].exp_we));
      end
      idle(2);

      // ---- single mult result with WB idle ----
      mul(1'b1, 5'd7, 32'h12); push(5'd7, 32'h12);
      @(negedge clk);
      mul_valid = 1'b0;
`ifdef RF_ARB_BYPASS_EN
      chk("t2_bypass_rf_we", 64'(rf_we),      64'd1);
      chk("t2_bypass_pend",  64'(pend_flags), 64'd0);
`else
      chk("t2_pend_set",     64'(pend_flags), 64'h80);
      chk("t2_rf_we_early",  64'(rf_we),      64'd0);
      @(negedge clk);
      chk("t2_rf_we",        64'(rf_we),      64'd1);
      chk("t2_pend_clear",   64'(pend_flags), 64'd0);
`endif
      idle(2);

      // ---- mult x0 is dropped ----
      mul(1'b1, 5'd0, 32'hBAD);
      @(negedge clk);
      mul_valid = 1'b0;
      chk("x0_pend", 64'(pend_flags), 64'd0);
      chk("x0_rf_we", 64'(rf_we), 64'd0);
      @(negedge clk);
      chk("x0_rf_we_late", 64'(rf_we), 64'd0);
      idle(2);

      // ---- starvation: WB held, one queued result gets a forced slot ----
      wb(1'b1, 5'd16, 32'h100); mul(1'b1, 5'd9, 32'h900); push(5'd16, 32'h100);
      @(negedge clk);
      mul_valid = 1'b0;
      chk("t3_pend9", 64'(pend_flags), 64'h200);
      for (int k = 1; k <= 3; k++) begin
         chk($sformatf("t3_ready_grant%0d", k), 64'(wb_ready), 64'd1);
         wb(1'b1, ADDR_W'(16 + k), 32'h100 + 32'(k)); push(ADDR_W'(16 + k), 32'h100 + 32'(k));
         @(negedge clk);
      end
      chk("t3_force_ready", 64'(wb_ready), 64'd0);
      wb(1'b1, 5'd20, 32'h104); push(5'd9, 32'h900);
      @(negedge clk);
      chk("t3_ready_back", 64'(wb_ready), 64'd1);
      chk("t3_mul_write",  64'(rf_we),    64'd1);
      push(5'd20, 32'h104);
      @(negedge clk);
      idle(2);

      // ---- fill FIFO while WB busy; 5th result refused ----
      for (int k = 0; k < 4; k++) begin
         wb(1'b1, ADDR_W'(20 + k), 32'h200 + 32'(k)); push(ADDR_W'(20 + k), 32'h200 + 32'(k));
         mul(1'b1, ADDR_W'(10 + k), 32'h300 + 32'(k));
         @(negedge clk);
      end
      chk("t4_full",      64'(fifo_full),  64'd1);
      chk("t4_mul_ready", 64'(mul_ready),  64'd0);
      chk("t4_wb_ready",  64'(wb_ready),   64'd0);
      chk("t4_pend_full", 64'(pend_flags), 64'h3C00);
      wb_valid = 1'b0;
      mul(1'b1, 5'd14, 32'h3FF);
      for (int k = 0; k < 4; k++) push(ADDR_W'(10 + k), 32'h300 + 32'(k));
      @(negedge clk);
      mul_valid = 1'b0;
      chk("t4_not_full", 64'(fifo_full),  64'd0);
      chk("t4_pend_no14", 64'(pend_flags), 64'h3800);
      idle(4);
      chk("t4_pend_empty", 64'(pend_flags), 64'd0);

      // ---- drain with 3 queued entries ----
      for (int k = 0; k < 3; k++) begin
         wb(1'b1, ADDR_W'(24 + k), 32'h400 + 32'(k)); push(ADDR_W'(24 + k), 32'h400 + 32'(k));
         mul(1'b1, ADDR_W'(3 + k), 32'h500 + 32'(k));
         @(negedge clk);
      end
      mul_valid = 1'b0; drain_req = 1'b1;
      wb(1'b1, 5'd27, 32'h403); push(5'd27, 32'h403);
      @(negedge clk);
      chk("t5_drain_ready", 64'(wb_ready),   64'd0);
      chk("t5_pend3",       64'(pend_flags), 64'h38);
      drain_req = 1'b0;
      wb(1'b1, 5'd28, 32'h404);
      for (int k = 0; k < 3; k++) push(ADDR_W'(3 + k), 32'h500 + 32'(k));
      push(5'd28, 32'h404);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("t5_drain_we%0d", k),    64'(rf_we),      64'd1);
         chk($sformatf("t5_drain_ready%0d", k), 64'(wb_ready),   64'd0);
         chk($sformatf("t5_done_low%0d", k),    64'(drain_done), 64'd0);
      end
      @(negedge clk);
      chk("t5_done_pulse", 64'(drain_done), 64'd1);
      chk("t5_ready_back", 64'(wb_ready),   64'd1);
      chk("t5_gap_we",     64'(rf_we),      64'd0);
      @(negedge clk);
      wb_valid = 1'b0;
      chk("t5_done_clear", 64'(drain_done), 64'd0);
      chk("t5_wb_after",   64'(rf_we),      64'd1);
      idle(2);

      // ---- reset in the middle of a drain ----
      wb(1'b1, 5'd29, 32'h600); mul(1'b1, 5'd6, 32'h700); push(5'd29, 32'h600);
      @(negedge clk);
      wb(1'b1, 5'd30, 32'h601); mul(1'b1, 5'd8, 32'h701); push(5'd30, 32'h601);
      @(negedge clk);
      mul_valid = 1'b0; drain_req = 1'b1;
      wb(1'b1, 5'd2, 32'h602); push(5'd2, 32'h602);
      @(negedge clk);
      chk("t6_in_drain", 64'(wb_ready), 64'd0);
      wb_valid = 1'b0; drain_req = 1'b0; push(5'd6, 32'h700);
      @(negedge clk);
      chk("t6_first_drain_we", 64'(rf_we), 64'd1);
      #2 rst = 1'b0;
      sb.delete();
      #1;
      chk("t6_rst_rf_we",      64'(rf_we),      64'd0);
      chk("t6_rst_rf_waddr",   64'(rf_waddr),   64'd0);
      chk("t6_rst_rf_wdata",   64'(rf_wdata),   64'd0);
      chk("t6_rst_drain_done", 64'(drain_done), 64'd0);
      chk("t6_rst_pend",       64'(pend_flags), 64'd0);
      chk("t6_rst_full",       64'(fifo_full),  64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("t6_post_ready%0d", k), 64'(wb_ready),   64'd1);
         chk($sformatf("t6_post_we%0d", k),    64'(rf_we),      64'd0);
         chk($sformatf("t6_post_pend%0d", k),  64'(pend_flags), 64'd0);
      end

      idle(2);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_rf_wport_arbiter
`default_nettype wire
